// File: rtl/core_bus_bridge_pkg.sv
// Shared bus types, bridge state encoding and request-building helpers.
package core_bus_bridge_pkg;

    typedef logic [31:0] addr_t;
    typedef logic [63:0] word_t;
    typedef logic [7:0]  strobe_t;
    typedef logic [7:0]  axi_len_t;

    typedef enum logic [2:0] {
        MSIZE1 = 3'd0,
        MSIZE2 = 3'd1,
        MSIZE4 = 3'd2,
        MSIZE8 = 3'd3
    } msize_t;

    typedef enum logic [1:0] {
        AXI_BURST_FIXED = 2'b00,
        AXI_BURST_INCR  = 2'b01,
        AXI_BURST_WRAP  = 2'b10
    } axi_burst_t;

    typedef struct packed {
        logic  valid;
        addr_t addr;
    } ibus_req_t;

    typedef struct packed {
        logic        addr_ok;
        logic        data_ok;
        logic [31:0] data;
    } ibus_resp_t;

    typedef struct packed {
        logic    valid;
        addr_t   addr;
        msize_t  size;
        strobe_t strobe;
        word_t   data;
    } dbus_req_t;

    typedef struct packed {
        logic  addr_ok;
        logic  data_ok;
        word_t data;
    } dbus_resp_t;

    typedef struct packed {
        logic       valid;
        logic       is_write;
        msize_t     size;
        addr_t      addr;
        strobe_t    strobe;
        word_t      data;
        axi_len_t   len;
        axi_burst_t burst;
    } cbus_req_t;

    typedef struct packed {
        logic  ready;
        logic  last;
        word_t data;
    } cbus_resp_t;

    typedef enum logic [1:0] {
        StIdle,
        StBusyI,
        StBusyD,
        StResp
    } bridge_state_t;

    // Fetches are always aligned 32-bit reads.
    function automatic cbus_req_t ibus_to_cbus(input addr_t addr);
        cbus_req_t c;
        c          = '0;
        c.valid    = 1'b1;
        c.is_write = 1'b0;
        c.size     = MSIZE4;
        c.addr     = addr;
        c.strobe   = '0;
        c.len      = '0;
        c.burst    = AXI_BURST_FIXED;
        return c;
    endfunction

    // A data access is a write exactly when any byte lane is enabled.
    function automatic cbus_req_t dbus_to_cbus(input addr_t addr, input msize_t size,
                                               input strobe_t strobe, input word_t data);
        cbus_req_t c;
        c          = '0;
        c.valid    = 1'b1;
        c.is_write = (strobe != '0);
        c.size     = size;
        c.addr     = addr;
        c.strobe   = strobe;
        c.data     = data;
        c.len      = '0;
        c.burst    = AXI_BURST_FIXED;
        return c;
    endfunction

endpackage

// File: rtl/cbus_rr_arbiter.sv
// Two-way round-robin grant between ibus and dbus; priority flips to the
// master that was not served by the most recent completed transaction.
module cbus_rr_arbiter (
    input  logic clk,
    input  logic reset,
    input  logic ireq_valid,
    input  logic dreq_valid,
    input  logic served,
    input  logic served_dbus,
    output logic grant_ibus,
    output logic grant_dbus
);

    // 0: dbus wins a tie, 1: ibus wins a tie.
    logic prio_ibus_q;

    // Remember who was served last so the other master wins the next tie.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prio_ibus_q <= 1'b0;
        end else if (served) begin
            prio_ibus_q <= served_dbus;
        end
    end

    // Combinational grant from the current requests and tie-break bit.
    always_comb begin
        grant_dbus = dreq_valid && (!ireq_valid || !prio_ibus_q);
        grant_ibus = ireq_valid && (!dreq_valid || prio_ibus_q);
    end

endmodule

// File: rtl/core_bus_bridge.sv
// Bridges an instruction bus and a data bus onto one single-beat cbus port.
// One transaction is in flight at a time; requests are not queued.
module core_bus_bridge
    import core_bus_bridge_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  ibus_req_t  ireq,
    output ibus_resp_t iresp,
    input  dbus_req_t  dreq,
    output dbus_resp_t dresp,
    output cbus_req_t  oreq,
    input  cbus_resp_t oresp
);

    bridge_state_t state_q, state_d;
    cbus_req_t     req_q, req_d;
    logic          owner_dbus_q, owner_dbus_d;
    word_t         data_q, data_d;

    logic idle, busy, served;
    logic grant_ibus, grant_dbus;

    assign idle   = (state_q == StIdle);
    assign busy   = (state_q == StBusyI) || (state_q == StBusyD);
    assign served = busy && oresp.ready && oresp.last;

    cbus_rr_arbiter u_arb (
        .clk         (clk),
        .reset       (reset),
        .ireq_valid  (idle && ireq.valid),
        .dreq_valid  (idle && dreq.valid),
        .served      (served),
        .served_dbus (owner_dbus_q),
        .grant_ibus  (grant_ibus),
        .grant_dbus  (grant_dbus)
    );

    // State, latched request, owner and captured read data.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= StIdle;
            req_q        <= '0;
            owner_dbus_q <= 1'b0;
            data_q       <= '0;
        end else begin
            state_q      <= state_d;
            req_q        <= req_d;
            owner_dbus_q <= owner_dbus_d;
            data_q       <= data_d;
        end
    end

    // Next state, request latch and master-facing handshakes.
    always_comb begin
        state_d      = state_q;
        req_d        = req_q;
        owner_dbus_d = owner_dbus_q;
        data_d       = data_q;
        iresp        = '0;
        dresp        = '0;
        unique case (state_q)
            StIdle: begin
                if (grant_dbus) begin
                    dresp.addr_ok = 1'b1;
                    req_d         = dbus_to_cbus(dreq.addr, dreq.size, dreq.strobe, dreq.data);
                    owner_dbus_d  = 1'b1;
                    state_d       = StBusyD;
                end else if (grant_ibus) begin
                    iresp.addr_ok = 1'b1;
                    req_d         = ibus_to_cbus(ireq.addr);
                    owner_dbus_d  = 1'b0;
                    state_d       = StBusyI;
                end
            end
            StBusyI, StBusyD: begin
                // ready without last is a stray beat and is ignored.
                if (served) begin
                    data_d  = oresp.data;
                    state_d = StResp;
                end
            end
            StResp: begin
                if (owner_dbus_q) begin
                    dresp.data_ok = 1'b1;
                    dresp.data    = data_q;
                end else begin
                    iresp.data_ok = 1'b1;
                    iresp.data    = req_q.addr[2] ? data_q[63:32] : data_q[31:0];
                end
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // Outbound request comes only from the latch, and only while busy.
    always_comb begin
        oreq = '0;
        if (busy) begin
            oreq = req_q;
        end
    end

endmodule
